// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcodes, FSM states and opcode legality.
// Optional feature macro: ALU_SEQ_MUL_EN (enables MUL opcode 1010).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

  // MUL is only legal when the multiplier is built.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLTU, OP_SLT, OP_SRA: legal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: retires MUL_BITS multiplier bits per cycle,
// finishing WIDTH/MUL_BITS cycles after start. product is the low WIDTH bits.
// done is asserted during the final step; product is valid in that cycle.
module alu_seq_mul #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_step;

  // Accumulator after adding this cycle's MUL_BITS partial products.
  always_comb begin
    acc_step = acc_q;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) begin
        acc_step = acc_step + (mcand_q << i);
      end else begin
        acc_step = acc_step;
      end
    end
  end

  // Load on start, otherwise shift-add while busy.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = {WIDTH{1'b0}};
      cnt_d    = CNT_W'(STEPS);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      acc_d    = acc_step;
      cnt_d    = cnt_q - CNT_W'(1);
      busy_d   = (cnt_q != CNT_W'(1));
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(1));
  assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered result.
// Optional feature macro: ALU_SEQ_MUL_EN builds the BUSY path and the
// iterative multiplier; without it opcode 1010 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             op_legal;
  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  shamt;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign shamt    = operand_b[SH_W-1:0];
  assign op_legal = is_legal_op(op);
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle operations.
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  alu_res = operand_a + operand_b;
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_SLL:  alu_res = operand_a << shamt;
      OP_SRL:  alu_res = operand_a >> shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
      default: alu_res = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  alu_seq_mul #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = {WIDTH{1'b0}};
`endif

  // Next-state and result-register update logic.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (op == OP_MUL) begin
            state_d     = BUSY;
            mul_start   = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            state_d     = DONE;
            result_d    = op_legal ? alu_res : {WIDTH{1'b0}};
            zero_d      = op_legal ? (alu_res == {WIDTH{1'b0}}) : 1'b1;
            illegal_d   = ~op_legal;
            out_valid_d = 1'b1;
          end
`else
          state_d     = DONE;
          result_d    = op_legal ? alu_res : {WIDTH{1'b0}};
          zero_d      = op_legal ? (alu_res == {WIDTH{1'b0}}) : 1'b1;
          illegal_d   = ~op_legal;
          out_valid_d = 1'b1;
`endif
        end else if ((state_q == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = state_q;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (mul_done) begin
          state_d     = DONE;
          result_d    = mul_product;
          zero_d      = (mul_product == {WIDTH{1'b0}});
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end else if (!mul_busy) begin
          // Multiplier lost its operation; recover to IDLE.
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = BUSY;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops
// compared against a behavioural reference model.
module tb_alu_seq;

  localparam int W  = 32;
  localparam int MB = 1;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W), .MUL_BITS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: what the ALU should compute for one operation.
  task automatic ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ill);
    int sh;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sh  = int'(b % W);
    sa  = a;
    sb  = b;
    ill = 1'b0;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = (a < b) ? 1 : 0;
      4'd8:  r = (sa < sb) ? 1 : 0;
      4'd9:  r = sa >>> sh;
      4'd10: begin
        if (MUL_EN) r = a * b;
        else begin r = '0; ill = 1'b1; end
      end
      default: begin r = '0; ill = 1'b1; end
    endcase
  endtask

  // Issue one op from IDLE, check latency/result, hold in DONE, then drain.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic         ei;
    int           n;
    int           rdy_hi;
    int           exp_lat;
    ref_alu(o, a, b, er, ei);
    exp_lat = (MUL_EN && o == 4'd10) ? (W / MB + 1) : 1;
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; op = 4'($urandom);
    n = 1; rdy_hi = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    check("busy_in_ready", rdy_hi, 0);
    check("result", result, er);
    check("zero", zero, (er == '0));
    check("illegal", illegal, ei);
    for (int i = 0; i < hold; i++) begin
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, er);
    end
    out_ready = 1'b1; #1;
    check("done_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] corners [6];
    logic [W-1:0] a;
    logic [W-1:0] b;
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001; corners[5] = 32'h0000_001F;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0;
    operand_a = '0; operand_b = '0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Directed cases.
    run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 1);
    run_op(4'd1, 32'd5, 32'd7, 0);
    run_op(4'd7, 32'h8000_0000, 32'h1, 0);
    run_op(4'd8, 32'h8000_0000, 32'h1, 0);
    run_op(4'd9, 32'h8000_0000, 32'h24, 0);
    run_op(4'd6, 32'h8000_0000, 32'h24, 0);
    run_op(4'd10, 32'h0001_0003, 32'h0000_0005, 2);
    run_op(4'd15, 32'h1234_5678, 32'h9, 0);

    // Backpressure then back-to-back transfer.
    in_valid = 1'b1; op = 4'd1; operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clk); #1;
    op = 4'd0; operand_a = 32'd2; operand_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'hFFFF_FFFE);
      @(posedge clk); #1;
    end
    check("bp_valid", out_valid, 1);
    check("bp_result_end", result, 32'hFFFF_FFFE);
    out_ready = 1'b1; #1;
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 32'd4);
    check("b2b_zero", zero, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drain", out_valid, 0);

    // Reset mid-operation.
    in_valid = 1'b1; op = 4'd10; operand_a = 32'h0001_0003; operand_b = 32'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_illegal", illegal, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_valid2", out_valid, 0);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      run_op(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
